c1_distributor: RTL and testbench
=================================

C1_DISTRIBUTOR -- requirements
Module: c1_distributor

Interface
REQ-001 Parameter SIZE, default 5, data word width in bits.
REQ-002 Parameter CNTW, default 8, width of accepted-word counter.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-005 D  input  SIZE  data word to be distributed.
REQ-006 in_valid  input  1  D and selects valid this cycle.
REQ-007 in_ready  output  1  block can accept D this cycle.
REQ-008 SA, SB, S0, S1  input  1 each  destination select; sampled together with D.
REQ-009 A0, A1, B0, B1  output  SIZE each  per-destination data registers.
REQ-010 A0_valid, A1_valid, B0_valid, B1_valid  output  1 each  destination slot holds a word.
REQ-011 A0_ready, A1_ready, B0_ready, B1_ready  input  1 each  consumer takes the slot word this cycle.
REQ-012 count  output  CNTW  total words accepted since reset.

Function
REQ-013 Destination decode: S2 = S0 | S1; if S2 = 0, destination is A1 when SA = 1, else A0; if S2 = 1, destination is B1 when SB = 1, else B0.
REQ-014 SA is ignored when S2 = 1; SB is ignored when S2 = 0.
REQ-015 Each destination has one 1-entry slot with states EMPTY and FULL.
REQ-016 in_ready = destination slot EMPTY, OR destination slot FULL with its X_ready = 1 (same-cycle drain and refill); in_ready is combinational from the selects and the slot state.
REQ-017 A word is accepted when in_valid & in_ready; on the next edge it is loaded into the destination register and the slot becomes FULL.
REQ-018 Latency: a word accepted in cycle N is visible with X_valid = 1 in cycle N+1.
REQ-019 Slot transitions: EMPTY->FULL on accept; FULL->EMPTY on X_ready with no accept to that slot; FULL->FULL with new data on X_ready plus accept; FULL holds on no X_ready.
REQ-020 While FULL with X_ready = 0, X and X_valid remain stable.
REQ-021 X_ready while the slot is EMPTY has no effect.
REQ-022 At most one word is accepted per cycle; non-destination slots are unaffected by the accept.
REQ-023 Several slots drain in the same cycle independently.
REQ-024 count increments by 1 per accepted word, modulo 2^CNTW (wraps from all-ones to 0).
REQ-025 Selects and D are don't-care when in_valid = 0; in_ready still reflects the decoded destination.

Reset
REQ-026 When rst_n = 0 at an edge: all slots EMPTY, all X_valid = 0, all X = 0, count = 0.
REQ-027 Reset takes priority over any accept or drain in the same cycle; words held in slots are discarded.
REQ-028 Accept is possible in the first cycle after rst_n returns to 1.

Structure
REQ-029 Shared package c1_pkg holds the SIZE default, CNTW default, and the 2-bit destination index encoding (A0 = 0, A1 = 1, B0 = 2, B1 = 3) plus the decode function of REQ-013.
REQ-030 One sub-module c1_slot (1-entry register, valid flag, load/drain logic) is instantiated four times; the top holds the decode, ready mux, and counter.

Verification
REQ-031 Reset then D=5'h0A, S0=0,S1=0,SA=1, in_valid one cycle -> next cycle A1=5'h0A, A1_valid=1, others 0, count=1.
REQ-032 A0 FULL, A0_ready=0, send to A0 -> in_ready=0, no accept, count unchanged; assert A0_ready with in_valid -> drain and refill same cycle, A0 shows new word next cycle.
REQ-033 Walk S1=1,SB=0 / S0=1,SB=1 / S0=1,S1=1,SA=1,SB=0 with D=3,4,7 -> B0=3, B1=4, then B0 blocked (in_ready=0) because B0 already FULL.
REQ-034 Fill all four slots, assert all four X_ready in one cycle -> all X_valid=0 next cycle.
REQ-035 CNTW=8, accept 257 words with consumers always ready -> count=1.
REQ-036 rst_n=0 during a cycle with in_valid=1 and in_ready=1 -> next cycle all slots EMPTY, count=0.

Source files
------------

// File: rtl/c1_pkg.sv
// Shared definitions for the c1 distributor: default widths, destination
// index encoding, slot state encoding and the select decode function.
package c1_pkg;

   localparam int unsigned SIZE_DEF = 5;
   localparam int unsigned CNTW_DEF = 8;
   localparam int unsigned NUM_DST  = 4;

   typedef enum logic [1:0] {
      DST_A0 = 2'd0,
      DST_A1 = 2'd1,
      DST_B0 = 2'd2,
      DST_B1 = 2'd3
   } dst_e;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_e;

   // S0|S1 picks the B pair (steered by SB), otherwise the A pair (steered by SA)
   function automatic dst_e decode_dst(input logic sa, input logic sb,
                                       input logic s0, input logic s1);
      logic s2;
      s2 = s0 | s1;
      if (s2) return sb ? DST_B1 : DST_B0;
      else    return sa ? DST_A1 : DST_A0;
   endfunction

endpackage

// File: rtl/c1_slot.sv
// One-entry destination slot: data register plus EMPTY/FULL state.
// Ports: clk, rst_n (sync, active-low), load (accept targets this slot),
//        data (word to load), drain (consumer takes the word),
//        q (held word), valid (slot is FULL).
module c1_slot
   import c1_pkg::*;
#(
   parameter int unsigned W = SIZE_DEF
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] data,
   input  logic         drain,
   output logic [W-1:0] q,
   output logic         valid
);

   slot_state_e  state;
   slot_state_e  state_nxt;
   logic [W-1:0] q_nxt;

   // State and data registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= SLOT_EMPTY;
         q     <= '0;
      end else begin
         state <= state_nxt;
         q     <= q_nxt;
      end
   end

   // Load wins over drain: a drain plus load in one cycle refills the slot
   always_comb begin
      state_nxt = state;
      q_nxt     = q;
      case (state)
         SLOT_EMPTY: begin
            if (load) begin
               state_nxt = SLOT_FULL;
               q_nxt     = data;
            end
         end
         SLOT_FULL: begin
            if (load) begin
               q_nxt = data;
            end else if (drain) begin
               state_nxt = SLOT_EMPTY;
            end
         end
         default: state_nxt = SLOT_EMPTY;
      endcase
   end

   assign valid = (state == SLOT_FULL);

endmodule

// File: rtl/c1_distributor.sv
// Routes one input word per cycle to one of four 1-entry slots (A0/A1/B0/B1)
// chosen by SA/SB/S0/S1, and counts accepted words.
// Ports: clk, rst_n (sync, active-low); D/in_valid/in_ready input handshake;
//        SA, SB, S0, S1 destination selects; A0..B1 slot data with
//        X_valid/X_ready consumer handshakes; count = words accepted.
module c1_distributor
   import c1_pkg::*;
#(
   parameter int unsigned SIZE = SIZE_DEF,
   parameter int unsigned CNTW = CNTW_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [SIZE-1:0] D,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            SA,
   input  logic            SB,
   input  logic            S0,
   input  logic            S1,
   output logic [SIZE-1:0] A0,
   output logic [SIZE-1:0] A1,
   output logic [SIZE-1:0] B0,
   output logic [SIZE-1:0] B1,
   output logic            A0_valid,
   output logic            A1_valid,
   output logic            B0_valid,
   output logic            B1_valid,
   input  logic            A0_ready,
   input  logic            A1_ready,
   input  logic            B0_ready,
   input  logic            B1_ready,
   output logic [CNTW-1:0] count
);

   dst_e               dst;
   logic               accept;
   logic [NUM_DST-1:0] slot_valid;
   logic [NUM_DST-1:0] slot_ready;
   logic [NUM_DST-1:0] load;
   logic [SIZE-1:0]    slot_q [NUM_DST];

   assign dst        = decode_dst(SA, SB, S0, S1);
   assign slot_ready = {B1_ready, B0_ready, A1_ready, A0_ready};

   // Ready when the chosen slot is empty or is being drained this cycle
   assign in_ready = !slot_valid[dst] || slot_ready[dst];
   assign accept   = in_valid && in_ready;

   // One-hot load strobe toward the decoded destination
   always_comb begin
      load      = '0;
      load[dst] = accept;
   end

   for (genvar i = 0; i < NUM_DST; i++) begin : g_slot
      c1_slot #(.W(SIZE)) u_slot (
         .clk   (clk),
         .rst_n (rst_n),
         .load  (load[i]),
         .data  (D),
         .drain (slot_ready[i]),
         .q     (slot_q[i]),
         .valid (slot_valid[i])
      );
   end

   assign A0       = slot_q[0];
   assign A1       = slot_q[1];
   assign B0       = slot_q[2];
   assign B1       = slot_q[3];
   assign A0_valid = slot_valid[0];
   assign A1_valid = slot_valid[1];
   assign B0_valid = slot_valid[2];
   assign B1_valid = slot_valid[3];

   // Accepted-word counter, wraps naturally
   always_ff @(posedge clk) begin
      if (!rst_n)      count <= '0;
      else if (accept) count <= count + CNTW'(1);
   end

endmodule

// File: tb/tb_c1_distributor.sv
// Self-checking bench for c1_distributor: directed scenarios plus randomized
// traffic, all compared against a slot/queue-level reference model.
module tb_c1_distributor;

   localparam int unsigned SIZE = 5;
   localparam int unsigned CNTW = 8;

   logic            clk;
   logic            rst_n;
   logic [SIZE-1:0] d;
   logic            in_valid;
   logic            in_ready;
   logic            sa, sb, s0, s1;
   logic [SIZE-1:0] a0, a1, b0, b1;
   logic [3:0]      vld;
   logic [3:0]      rdy;
   logic [CNTW-1:0] count;
   logic [SIZE-1:0] dq [4];

   int checks;
   int errors;

   // Reference model: per-destination occupancy/data and accepted-word total
   bit              m_full [4];
   logic [SIZE-1:0] m_data [4];
   int unsigned     m_cnt;

   c1_distributor #(.SIZE(SIZE), .CNTW(CNTW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .D        (d),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .SA       (sa),
      .SB       (sb),
      .S0       (s0),
      .S1       (s1),
      .A0       (a0),
      .A1       (a1),
      .B0       (b0),
      .B1       (b1),
      .A0_valid (vld[0]),
      .A1_valid (vld[1]),
      .B0_valid (vld[2]),
      .B1_valid (vld[3]),
      .A0_ready (rdy[0]),
      .A1_ready (rdy[1]),
      .B0_ready (rdy[2]),
      .B1_ready (rdy[3]),
      .count    (count)
   );

   assign dq[0] = a0;
   assign dq[1] = a1;
   assign dq[2] = b0;
   assign dq[3] = b1;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int dest();
      if (s0 || s1) return sb ? 3 : 2;
      return sa ? 1 : 0;
   endfunction

   function automatic bit m_ready();
      int k;
      k = dest();
      return !m_full[k] || rdy[k];
   endfunction

   function automatic logic [3:0] m_vld();
      logic [3:0] v;
      for (int i = 0; i < 4; i++) v[i] = m_full[i];
      return v;
   endfunction

   task automatic drive(input bit iv, input logic [SIZE-1:0] dv,
                        input bit a, input bit b, input bit z0, input bit z1,
                        input logic [3:0] r);
      in_valid = iv; d = dv; sa = a; sb = b; s0 = z0; s1 = z1; rdy = r;
      #1;
   endtask

   // Advance one clock and update the model from the inputs seen at the edge
   task automatic tick();
      int  k;
      bit  acc;
      @(posedge clk);
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            m_full[i] = 1'b0;
            m_data[i] = '0;
         end
         m_cnt = 0;
      end else begin
         k   = dest();
         acc = in_valid && m_ready();
         for (int i = 0; i < 4; i++)
            if (m_full[i] && rdy[i]) m_full[i] = 1'b0;
         if (acc) begin
            m_full[k] = 1'b1;
            m_data[k] = d;
            m_cnt++;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive(1'b1, 5'h1F, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
      tick();
      tick();
      checks++;
      if (vld !== 4'h0) begin
         errors++; $display("FAIL reset_valid got %b want 0000", vld);
      end
      checks++;
      if (count !== '0) begin
         errors++; $display("FAIL reset_count got %0d want 0", count);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (dq[i] !== '0) begin
            errors++; $display("FAIL reset_data[%0d] got %h want 00", i, dq[i]);
         end
      end
      rst_n = 1'b1;
   endtask

   task automatic test_first_word();
      drive(1'b1, 5'h0A, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL first_ready got %b want 1", in_ready);
      end
      tick();
      drive(1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
      checks++;
      if (a1 !== 5'h0A || vld !== 4'b0010) begin
         errors++; $display("FAIL first_word got A1=%h vld=%b want 0a 0010", a1, vld);
      end
      checks++;
      if (count !== 8'd1) begin
         errors++; $display("FAIL first_count got %0d want 1", count);
      end
   endtask

   task automatic test_backpressure();
      drive(1'b1, 5'h11, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
      tick();
      drive(1'b1, 5'h12, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
      checks++;
      if (in_ready !== 1'b0) begin
         errors++; $display("FAIL bp_blocked got %b want 0", in_ready);
      end
      tick();
      checks++;
      if (a0 !== 5'h11 || vld[0] !== 1'b1 || count !== 8'd2) begin
         errors++; $display("FAIL bp_hold got A0=%h v=%b cnt=%0d want 11 1 2", a0, vld[0], count);
      end
      drive(1'b1, 5'h12, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL bp_refill_ready got %b want 1", in_ready);
      end
      tick();
      drive(1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
      checks++;
      if (a0 !== 5'h12 || vld[0] !== 1'b1 || count !== 8'd3) begin
         errors++; $display("FAIL bp_refill got A0=%h v=%b cnt=%0d want 12 1 3", a0, vld[0], count);
      end
   endtask

   task automatic test_b_walk();
      drive(1'b1, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
      tick();
      drive(1'b1, 5'd4, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
      tick();
      drive(1'b1, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 4'h0);
      checks++;
      if (in_ready !== 1'b0) begin
         errors++; $display("FAIL bwalk_b0_blocked got %b want 0", in_ready);
      end
      tick();
      checks++;
      if (b0 !== 5'd3 || b1 !== 5'd4 || vld !== 4'hF) begin
         errors++; $display("FAIL bwalk_data got B0=%h B1=%h vld=%b want 03 04 1111", b0, b1, vld);
      end
      checks++;
      if (count !== 8'd5) begin
         errors++; $display("FAIL bwalk_count got %0d want 5", count);
      end
   endtask

   task automatic test_drain_all();
      drive(1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF);
      tick();
      drive(1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
      checks++;
      if (vld !== 4'h0) begin
         errors++; $display("FAIL drain_all got %b want 0000", vld);
      end
   endtask

   task automatic test_wrap();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int n = 0; n < 257; n++) begin
         drive(1'b1, SIZE'($urandom), 1'($urandom), 1'($urandom),
               1'($urandom), 1'($urandom), 4'hF);
         if (in_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL wrap_ready[%0d] got %b want 1", n, in_ready);
         end
         tick();
      end
      drive(1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF);
      checks++;
      if (count !== 8'd1) begin
         errors++; $display("FAIL wrap_count got %0d want 1", count);
      end
   endtask

   task automatic test_reset_priority();
      drive(1'b1, 5'h15, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
      tick();
      drive(1'b1, 5'h09, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      checks++;
      if (vld !== 4'h0 || count !== '0) begin
         errors++; $display("FAIL rst_prio got vld=%b cnt=%0d want 0000 0", vld, count);
      end
      drive(1'b1, 5'h1C, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
      tick();
      checks++;
      if (b1 !== 5'h1C || vld !== 4'b1000 || count !== 8'd1) begin
         errors++; $display("FAIL rst_first_accept got B1=%h vld=%b cnt=%0d want 1c 1000 1", b1, vld, count);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         rst_n = ($urandom_range(0, 59) != 0);
         drive(1'($urandom_range(0, 3) != 0), SIZE'($urandom), 1'($urandom),
               1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom));
         checks++;
         if (in_ready !== m_ready()) begin
            errors++; $display("FAIL rand_ready[%0d] got %b want %b", n, in_ready, m_ready());
         end
         tick();
         checks++;
         if (vld !== m_vld() || count !== CNTW'(m_cnt)) begin
            errors++; $display("FAIL rand_state[%0d] got vld=%b cnt=%0d want %b %0d",
                               n, vld, count, m_vld(), CNTW'(m_cnt));
         end
         for (int i = 0; i < 4; i++) begin
            if (m_full[i]) begin
               checks++;
               if (dq[i] !== m_data[i]) begin
                  errors++; $display("FAIL rand_data[%0d][%0d] got %h want %h", n, i, dq[i], m_data[i]);
               end
            end
         end
      end
      rst_n = 1'b1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      m_cnt  = 0;
      for (int i = 0; i < 4; i++) begin
         m_full[i] = 1'b0;
         m_data[i] = '0;
      end
      rst_n = 1'b0;
      drive(1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
      test_reset();
      test_first_word();
      test_backpressure();
      test_b_walk();
      test_drain_all();
      test_wrap();
      test_reset_priority();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
